// File: rtl/digit_entry_rpn.sv
// digit_entry_rpn: keypad-to-binary operand entry for the 8-bit RPN ULA.
// Accumulates one digit per key press in decimal, hex or octal. It rejects
// invalid digits, values above 255 and extra digits. Enter commits the value
// as Operando with a one-cycle OperandoValido strobe.
// Optional feature macro: DEBOUNCE_EN adds a per-key debouncer ahead of the
// edge detectors. The default build uses raw key levels.
module digit_entry_rpn #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Digito,
  input  logic       DigitoKey,
  input  logic       EnterKey,
  input  logic       LimparKey,
  input  logic [1:0] Base,
  output logic [7:0] Acumulado,
  output logic [7:0] Operando,
  output logic       OperandoValido,
  output logic [1:0] NumDigitos,
  output logic       Erro
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ENTRY = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  // Key bit positions inside the packed key vectors
  localparam int KEY_DIG = 0;
  localparam int KEY_ENT = 1;
  localparam int KEY_LIM = 2;

  // The debounce counter must be able to reach the configured hold time
  if (2 ** CNT_W <= DEBOUNCE_CYCLES) begin : g_cnt_w_check
    $error("CNT_W too small for DEBOUNCE_CYCLES");
  end

  logic [2:0] key_raw;
  logic [2:0] key_lvl;

  assign key_raw = {LimparKey, EnterKey, DigitoKey};

`ifdef DEBOUNCE_EN
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [2:0]       filt_q;
  logic [2:0]       filt_d;

  // Filtered level follows the raw key only after it has held a new level for DEBOUNCE_CYCLES cycles
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i]  = cnt_q[i];
      filt_d[i] = filt_q[i];
      if (key_raw[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_d[i] = key_raw[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Debounce state registers, cleared by reset
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      filt_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign key_lvl = filt_q;
`else
  assign key_lvl = key_raw;
`endif

  state_t      state_q, state_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  oper_q, oper_d;
  logic        valid_q, valid_d;
  logic [1:0]  num_q, num_d;
  logic        erro_q, erro_d;
  logic [1:0]  base_q, base_d;
  logic [2:0]  hist_q, hist_d;

  logic [2:0]  key_ev;
  logic [11:0] radix;
  logic [1:0]  max_digits;
  logic [11:0] cand;
  logic        digit_ok;

  // Radix and digit limit for the registered base; code 11 behaves as decimal
  always_comb begin
    radix      = 12'd10;
    max_digits = 2'd3;
    case (base_q)
      2'b01: begin
        radix      = 12'd16;
        max_digits = 2'd2;
      end
      2'b10: begin
        radix      = 12'd8;
        max_digits = 2'd3;
      end
      default: begin
        radix      = 12'd10;
        max_digits = 2'd3;
      end
    endcase
  end

  // Candidate value is kept at 12 bits so an overflow past 255 is visible
  assign cand     = 12'(acc_q) * radix + 12'(Digito);
  assign digit_ok = (12'(Digito) < radix) && (cand <= 12'd255) && (num_q < max_digits);
  assign key_ev   = key_lvl & ~hist_q;

  // Next-state logic: base change beats Limpar, Limpar beats Enter, Enter beats a digit
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    oper_d  = oper_q;
    valid_d = 1'b0;
    num_d   = num_q;
    base_d  = base_q;
    hist_d  = key_lvl;
    if (Base != base_q) begin
      base_d  = Base;
      acc_d   = '0;
      num_d   = '0;
      state_d = ST_EMPTY;
    end else if (key_ev[KEY_LIM]) begin
      acc_d   = '0;
      num_d   = '0;
      state_d = ST_EMPTY;
    end else if (key_ev[KEY_ENT]) begin
      if (state_q == ST_ENTRY) begin
        oper_d  = acc_q;
        valid_d = 1'b1;
        acc_d   = '0;
        num_d   = '0;
        state_d = ST_EMPTY;
      end
    end else if (key_ev[KEY_DIG]) begin
      if (state_q != ST_ERROR) begin
        if (digit_ok) begin
          acc_d   = cand[7:0];
          num_d   = num_q + 2'd1;
          state_d = ST_ENTRY;
        end else begin
          state_d = ST_ERROR;
        end
      end
    end
    erro_d = (state_d == ST_ERROR);
  end

  // Entry FSM and registered outputs; reset discards any entry in progress
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_EMPTY;
      acc_q   <= '0;
      oper_q  <= '0;
      valid_q <= 1'b0;
      num_q   <= '0;
      erro_q  <= 1'b0;
      base_q  <= Base;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      oper_q  <= oper_d;
      valid_q <= valid_d;
      num_q   <= num_d;
      erro_q  <= erro_d;
      base_q  <= base_d;
      hist_q  <= hist_d;
    end
  end

  assign Acumulado      = acc_q;
  assign Operando       = oper_q;
  assign OperandoValido = valid_q;
  assign NumDigitos     = num_q;
  assign Erro           = erro_q;

endmodule
